// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, the
// reset-vector base address and the number of bytes packed per word.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Reset-vector base; the instruction ROM decodes the same range.
  localparam logic [31:0] BASE_ADDR = 32'hBFC00000;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Lane buffer for one memory word: collects stream bytes into their
// little-endian lanes and tracks which lanes have been filled.
module byte_packer
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = WORD_BYTES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          load_en,
  input  logic [$clog2(LANES)-1:0]      lane,
  input  logic [DATA_WIDTH-1:0]         byte_in,
  output logic [LANES*DATA_WIDTH-1:0]   word,
  output logic [LANES-1:0]              be
);

  logic [LANES*DATA_WIDTH-1:0] word_q, word_d;
  logic [LANES-1:0]            be_q, be_d;

  // Clear wins over load so a finished word never leaks into the next one.
  always_comb begin
    word_d = word_q;
    be_d   = be_q;
    if (clr) begin
      word_d = '0;
      be_d   = '0;
    end else if (load_en) begin
      word_d[lane*DATA_WIDTH +: DATA_WIDTH] = byte_in;
      be_d[lane]                            = 1'b1;
    end
  end

  // Buffer and lane-enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      be_q   <= '0;
    end else begin
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

  assign word = word_q;
  assign be   = be_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader for instruction memory: accepts a byte stream, packs groups of
// four bytes little-endian and writes each word from the reset vector upward.
module imem_loader #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = ADDRESS_WIDTH'(imem_pkg::BASE_ADDR),
  parameter int                       MAX_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    byte_in,
  input  logic                     byte_valid,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [ADDRESS_WIDTH-1:0] mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  import imem_pkg::*;

  localparam int            CW      = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          last_q, last_d;

  logic                             pk_load;
  logic                             pk_clr;
  logic [WORD_BYTES*DATA_WIDTH-1:0] pk_word;
  logic [WORD_BYTES-1:0]            pk_be;

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (WORD_BYTES)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .load_en (pk_load),
    .lane    (cnt_q[1:0]),
    .byte_in (byte_in),
    .word    (pk_word),
    .be      (pk_be)
  );

  // Next-state, byte counter and sticky status; a session restart clears all of them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    pk_load = 1'b0;
    pk_clr  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          pk_load = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if ((cnt_q[1:0] == 2'd3) || byte_last || (cnt_d == MAX_CNT)) begin
            state_d = WRITE;
            last_d  = byte_last;
          end
        end
      end
      WRITE: begin
        pk_clr = 1'b1;
        if (last_q || (cnt_q == MAX_CNT)) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = ~last_q;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset drops any word still waiting to be written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Write port decoded from registered state only; the word address is the
  // index of the last accepted byte rounded down to a word boundary.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (state_q == WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = BASE_ADDR + ((ADDRESS_WIDTH'(cnt_q) - ADDRESS_WIDTH'(1)) & ~ADDRESS_WIDTH'(3));
      mem_wdata = ADDRESS_WIDTH'(pk_word);
      mem_be    = pk_be;
    end
  end

  assign byte_ready = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == WRITE);
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the byte-addressed, little-endian instruction ROM.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes little-endian into a 32-bit word.
- Issues word writes (with byte enables) into instruction memory starting at the reset-vector base.
- Sits between a boot/debug byte source and the instruction memory write port; the CPU is held off until done asserts.

Parameters:
ADDRESS_WIDTH, 32, width of memory address and data word
DATA_WIDTH, 8, width of one stream byte (byte addressing)
BASE_ADDR, 32'hBFC00000, byte address of the first word written
MAX_BYTES, 4096, capacity of the instruction region in bytes (multiple of 4)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse that begins a load session
byte_in  input  DATA_WIDTH  stream byte
byte_valid  input  1  byte_in is valid
byte_last  input  1  qualifies the accepted byte as the final byte of the image
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  one-cycle word write strobe
mem_addr  output  ADDRESS_WIDTH  word-aligned byte address of the write
mem_wdata  output  ADDRESS_WIDTH  packed word; stream byte k of the word in bits 8k+7:8k
mem_be  output  4  byte-lane enables for the write
busy  output  1  session in progress
done  output  1  image fully written; held until next start
overflow  output  1  image exceeded MAX_BYTES; held until next start

Behaviour:
- Reset (async, any state): state=IDLE, byte counter=0, lane buffer=0, and all outputs 0. Any pending write is dropped.
- States are IDLE, LOAD, WRITE and DONE.
- IDLE:
  - byte_ready=0, busy=0.
  - start -> LOAD: clears counter, done and overflow.
- LOAD:
  - byte_ready=1, busy=1.
  - A byte is accepted when byte_valid && byte_ready.
  - The accepted byte goes to lane cnt[1:0] of the buffer, its be bit is set, and cnt increments.
  - Transition to WRITE when the accepted byte fills lane 3, OR byte_last=1, OR cnt reaches MAX_BYTES.
- WRITE (exactly one cycle):
  - mem_we=1, byte_ready=0.
  - mem_addr = BASE_ADDR + 4*word_index, where word_index = (cnt-1)>>2.
  - mem_wdata=buffer, mem_be=lane enables.
  - Exit to LOAD if no final condition; else to DONE. Buffer and be are cleared on exit.
- Latency: the byte completing a word is accepted in cycle N; mem_we pulses in cycle N+1. Sustained throughput is 4 bytes per 5 cycles.
- Partial final word: byte_last on lane j writes be = lanes 0..j only; unused lanes of mem_wdata are 0.
- Overflow: accepting byte number MAX_BYTES without byte_last forces the final write, then DONE with overflow=1 and done=1.
  - byte_last on exactly byte MAX_BYTES sets done=1 with overflow=0.
- DONE:
  - done=1, busy=0, byte_ready=0.
  - start -> LOAD (re-arm); clears done and overflow on entry.
- Ignored inputs:
  - start in LOAD or WRITE is ignored.
  - byte_valid while byte_ready=0 is ignored; the source must hold its byte.
- mem_we is never asserted outside WRITE.
- Address arithmetic is ADDRESS_WIDTH-bit unsigned; no wrap occurs within MAX_BYTES.
- Outputs mem_addr, mem_wdata and mem_be are registered or decoded from registered state only, with no combinational path from inputs.

Decomposition:
- Shared package imem_pkg holds:
  - state enum {IDLE, LOAD, WRITE, DONE};
  - BASE_ADDR constant (shared with the ROM address range);
  - WORD_BYTES=4.
- One natural sub-module, byte_packer:
  - holds the lane buffer and be register;
  - inputs: load-lane enable, lane index, byte, clear.
- The FSM and counter stay in imem_loader.

Test Plan:
- Reset then start; stream 8 bytes 01..08 back-to-back, last on 08 -> two writes:
  - addr BFC00000, data 04030201, be 1111;
  - addr BFC00004, data 08070605, be 1111;
  - then done=1, overflow=0.
- Stream 6 bytes AA,BB,CC,DD,EE,FF, last on FF -> second write is addr BFC00004, data 0000FFEE, be 0011.
- Assert byte_valid continuously -> byte_ready=0 exactly in each WRITE cycle and no byte is lost. Check the mem_we pulse lands one cycle after the 4th-byte handshake.
- Stream 4097 bytes with MAX_BYTES=4096 and no last:
  - final write is addr BFC00FFC;
  - overflow=1, done=1;
  - byte_ready=0 afterwards.
- Assert rst mid-word after 2 bytes -> outputs 0 immediately and no mem_we. After start, the new image rewrites from BFC00000.
- In DONE, pulse start and stream 4 bytes -> done clears and a single write goes to BFC00000. A start pulse during LOAD has no effect on cnt.
